// File: rtl/regs_wb_arbiter.sv
// Register-file write-back arbiter: merges WB-stage writes with in-order multicycle results,
// tracks pending destinations for hazard stalls. Define REGS_WB_ARBITER_ERR_EN for sticky err.
module regs_wb_arbiter #(
  parameter int TAG_DEPTH = 4,
  parameter int CHK_PORTS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_we,
  input  logic [4:0]                pipe_waddr,
  input  logic [31:0]               pipe_wrdata,
  input  logic                      mc_issue,
  input  logic [4:0]                mc_waddr,
  output logic                      issue_ready,
  input  logic                      mc_valid,
  input  logic [31:0]               mc_wrdata,
  output logic                      mc_ready,
  input  logic                      flush,
  input  logic [CHK_PORTS-1:0][4:0] chk_addr,
  output logic                      pending_stall,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [31:0]               rf_wrdata,
  output logic                      err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);

  logic [4:0]       tag_q [TAG_DEPTH];
  logic [4:0]       tag_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hold_vld_q, hold_vld_d;
  logic [4:0]       hold_addr_q, hold_addr_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wrdata_q, rf_wrdata_d;

  logic             enq, hs, drain, pop;
  logic [4:0]       head_addr;
  logic [TAG_DEPTH-1:0] entry_vld;

  assign issue_ready = (count_q != CNT_FULL);
  assign mc_ready    = !hold_vld_q && (count_q != '0);
  assign head_addr   = tag_q[rd_ptr_q];

  // flush wins over every queue-side event; the pipe write still goes out
  assign enq   = mc_issue && issue_ready && !flush;
  assign hs    = mc_valid && mc_ready && !flush;
  assign drain = hold_vld_q && !pipe_we && !flush;
  assign pop   = drain || (hs && !pipe_we);

  always_comb begin
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wrdata_d = rf_wrdata_q;

    if (pipe_we) begin
      rf_we_d     = 1'b1;
      rf_waddr_d  = pipe_waddr;
      rf_wrdata_d = pipe_wrdata;
      if (hs) begin
        hold_vld_d  = 1'b1;
        hold_addr_d = head_addr;
        hold_data_d = mc_wrdata;
      end
    end else if (drain) begin
      rf_we_d     = 1'b1;
      rf_waddr_d  = hold_addr_q;
      rf_wrdata_d = hold_data_q;
      hold_vld_d  = 1'b0;
    end else if (hs) begin
      rf_we_d     = 1'b1;
      rf_waddr_d  = head_addr;
      rf_wrdata_d = mc_wrdata;
    end

    if (enq) begin
      tag_d[wr_ptr_q] = mc_waddr;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({enq, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      hold_vld_d = 1'b0;
    end
  end

  // an entry is live when its distance from the read pointer is below count
  always_comb begin
    entry_vld     = '0;
    pending_stall = 1'b0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      entry_vld[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
    for (int p = 0; p < CHK_PORTS; p++) begin
      if (chk_addr[p] != 5'd0) begin
        for (int i = 0; i < TAG_DEPTH; i++) begin
          if (entry_vld[i] && (tag_q[i] == chk_addr[p])) pending_stall = 1'b1;
        end
        if (mc_issue && (mc_waddr == chk_addr[p])) pending_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wrdata_q <= '0;
    end else begin
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wrdata_q <= rf_wrdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wrdata = rf_wrdata_q;

`ifdef REGS_WB_ARBITER_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q || (mc_issue && !issue_ready) || (mc_valid && (count_q == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/regs_wb_arbiter.md
REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_DEPTH, default 4, giving the maximum number of multicycle writes in flight (power of two, 2..8).
REQ-002 The block SHALL have parameter CHK_PORTS, default 3, giving the number of hazard-check address ports.
REQ-003 The block SHALL run on one clock and reset with these ports: clk  in  1  clock (rising edge); rst  in  1  asynchronous, active-low reset.
REQ-004 The pipeline write port SHALL be: pipe_we  in  1  WB-stage write request, always accepted; pipe_waddr  in  5  destination register; pipe_wrdata  in  32  write data.
REQ-005 The multicycle issue port SHALL be: mc_issue  in  1  multicycle op issued; mc_waddr  in  5  its destination register; issue_ready  out  1  tag queue not full.
REQ-006 The multicycle result port SHALL be: mc_valid  in  1  result valid; mc_wrdata  in  32  result of the oldest issued op; mc_ready  out  1  result accepted.
REQ-007 The flush input SHALL be: flush  in  1  discard all in-flight multicycle state.
REQ-008 The hazard-check port SHALL be: chk_addr  in  CHK_PORTS x 5  source and destination addresses from the ID stage; pending_stall  out  1  a checked register is pending.
REQ-009 The register-file write port SHALL be: rf_we  out  1  write enable (registered); rf_waddr  out  5  destination register (registered); rf_wrdata  out  32  write data (registered).
REQ-010 The error output SHALL be: err  out  1  sticky protocol error (see Configuration).

Function
REQ-011 The tag queue SHALL be a FIFO of TAG_DEPTH 5-bit destination addresses with a count in the range 0..TAG_DEPTH; pointers wrap modulo TAG_DEPTH.
REQ-012 An enqueue SHALL occur on mc_issue && issue_ready; issue_ready SHALL equal (count != TAG_DEPTH).
REQ-013 The hold buffer SHALL be a single {addr, data} entry; mc_ready SHALL equal (hold buffer empty) && (count != 0).
REQ-014 A handshake SHALL occur on mc_valid && mc_ready; it binds mc_wrdata to the queue-head address.
REQ-015 Port selection per cycle SHALL follow this priority: pipe_we > hold buffer > direct handshake.
  - pipe_we=1: output registers load the pipe write; any handshake this cycle loads the hold buffer.
  - else hold buffer full: output registers load the buffer, the buffer clears, the tag is popped.
  - else handshake: output registers load {head addr, mc_wrdata}, the tag is popped.
  - else rf_we=0 next cycle.
REQ-016 Write latency SHALL be 1 cycle for a pipeline write and 1–2 cycles for a multicycle result; a held result SHALL drain no later than the first cycle with pipe_we=0.
REQ-017 Pop and enqueue in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-018 pending_stall SHALL be combinational, asserted when any nonzero chk_addr[i] equals a valid queue entry or equals mc_waddr while mc_issue=1.
REQ-019 Register 0 SHALL never raise pending_stall; writes to address 0 SHALL pass through unchanged.
REQ-020 flush SHALL empty the queue and the hold buffer at the next edge and override enqueue, pop and handshake in that cycle.
REQ-021 A pipeline write in a flush cycle SHALL still reach the output registers.
REQ-022 A multicycle result SHALL only be written to rf_* after its tag is popped; no result SHALL be written twice or dropped absent flush.

Reset
REQ-023 When rst=0 (asynchronous), count, pointers, hold buffer, rf_we, rf_waddr, rf_wrdata and err SHALL all be 0.
REQ-024 Reset asserted mid-operation SHALL discard all pending tags and the held result without issuing any rf write.
REQ-025 The first rising edge after rst returns to 1 SHALL be able to accept an issue.

Configuration
REQ-026 With REGS_WB_ARBITER_ERR_EN defined, err SHALL set and hold until reset on mc_issue && !issue_ready, or mc_valid while count=0.
REQ-027 With REGS_WB_ARBITER_ERR_EN defined, the offending request SHALL be ignored.
REQ-028 Without REGS_WB_ARBITER_ERR_EN, err SHALL be tied to 0 and no error logic SHALL be present; the functional behaviour SHALL be otherwise identical.

Verification
REQ-029 Issue r5, then mc_valid with 0x1234 two cycles later, pipe_we=0 -> rf_we=1, rf_waddr=5, rf_wrdata=0x1234 one cycle after the handshake; pending_stall for chk_addr=5 drops after the pop.
REQ-030 Handshake with r7/0xAA in the same cycle as pipe_we r3/0x55 -> r3/0x55 written at cycle+1, r7/0xAA at cycle+2; mc_ready=0 at cycle+1.
REQ-031 Issue 4 ops (r1..r4) -> issue_ready=0; a fifth mc_issue with ERR_EN -> err=1 and count stays 4; results return in order r1..r4.
REQ-032 Issue r9, assert flush together with pipe_we r2/0x77 -> r2/0x77 written; count=0; pending_stall for r9 deasserted next cycle; mc_ready=0.
REQ-033 chk_addr={0,6,0} with mc_issue r6 in the same cycle -> pending_stall=1; mc_issue r0 with chk_addr={0,0,0} -> pending_stall=0.
REQ-034 Drop rst to 0 mid-sequence with 2 tags and a full hold buffer -> all outputs 0 immediately; no write after release.
